tdc_pair_diff: RTL and testbench



---
 rtl/tdc_pkg.sv | 35 +++
 rtl/tdc_dval_delay.sv | 52 +++++
 rtl/tdc_pair_diff.sv | 163 ++++++++++++++++
 tb/tb_tdc_pair_diff.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types, default widths and the saturation helper for the TDC
// pair-difference path.
package tdc_pkg;

  localparam int DEF_IN_W  = 37;
  localparam int DEF_OUT_W = 20;

  // Widest signed value sat_signed() can clamp; covers IN_W+2 for any
  // timestamp width up to 62 bits.
  localparam int SAT_MAX_W = 64;

  typedef enum logic {
    IDLE   = 1'b0,  // no sample held
    HAVE_A = 1'b1   // first sample held, timer running
  } diff_state_e;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  // The result is returned sign-extended, so comparing it with the input
  // tells whether clamping took place.
  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
    input logic signed [SAT_MAX_W-1:0] v,
    input int unsigned                 w
  );
    logic signed [SAT_MAX_W-1:0] one;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    one = SAT_MAX_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = -(one <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tdc_dval_delay.sv
// Fixed-depth delay line for a result strobe, its overflow flag and its data.
// Data stages capture only when a valid result moves into them, so the last
// stage keeps presenting the most recent result between strobes.
module tdc_dval_delay #(
  parameter int DEPTH  = 0,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ovf,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              out_valid
);

  if (DEPTH == 0) begin : g_pass
    assign out_data  = in_data;
    assign out_ovf   = in_ovf & in_valid;
    assign out_valid = in_valid;
  end else begin : g_delay
    logic [DEPTH-1:0]  v_sr;
    logic [DEPTH-1:0]  o_sr;
    logic [DATA_W-1:0] d_sr [DEPTH];

    // Shift strobe and flag every cycle; advance data only behind a strobe.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_sr <= '0;
        o_sr <= '0;
        // NOTE: this array is a handful of flops, not a RAM, so it is reset
        // along with everything else and out_data reads 0 after reset.
        for (int i = 0; i < DEPTH; i++) d_sr[i] <= '0;
      end else begin
        v_sr[0] <= in_valid;
        o_sr[0] <= in_ovf;
        if (in_valid) d_sr[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          v_sr[i] <= v_sr[i-1];
          o_sr[i] <= o_sr[i-1];
          if (v_sr[i-1]) d_sr[i] <= d_sr[i-1];
        end
      end
    end

    assign out_data  = d_sr[DEPTH-1];
    assign out_ovf   = o_sr[DEPTH-1] & v_sr[DEPTH-1];
    assign out_valid = v_sr[DEPTH-1];
  end

endmodule

// File: rtl/tdc_pair_diff.sv
// Pair-difference unit: groups consecutive timestamps into (first, second)
// pairs and emits second - first + OFFSET, saturated or truncated to OUT_W.
module tdc_pair_diff
  import tdc_pkg::*;
#(
  parameter int        IN_W       = DEF_IN_W,
  parameter int        OUT_W      = DEF_OUT_W,
  parameter int signed OFFSET     = 23,
  parameter int        TIMEOUT    = 1024,
  parameter int        DVAL_DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dval,
  input  logic [IN_W-1:0]  mlt,
  input  logic             sync,
  input  logic             sat_en,
  output logic [OUT_W-1:0] out_data,
  output logic             o_dval,
  output logic             o_ovf,
  output logic             o_timeout,
  output logic [15:0]      pair_cnt
);

  localparam int R_W   = IN_W + 2;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  diff_state_e       state;
  diff_state_e       state_nxt;
  logic [IN_W-1:0]   buf_a;
  logic [TMR_W-1:0]  timer;
  logic              take_first;
  logic              pair_done;
  logic              expire;

  // Pairing decisions. sync with dval restarts the pair on this sample; a
  // dval in the expiry cycle completes the pair instead of timing out.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt  = state;
    take_first = 1'b0;
    pair_done  = 1'b0;
    expire     = 1'b0;
    if (TIMEOUT != 0) expire = (state == HAVE_A) && (timer == TMR_W'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (dval) begin
          take_first = 1'b1;
          state_nxt  = HAVE_A;
        end
      end
      HAVE_A: begin
        if (dval && sync) begin
          take_first = 1'b1;
        end else if (dval) begin
          pair_done = 1'b1;
          state_nxt = IDLE;
        end else if (sync || expire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The drop pulse lands in the expiry cycle itself, so it is qualified by
  // the same-cycle inputs that would otherwise rescue or abandon the pair.
  assign o_timeout = expire & ~dval & ~sync;

  // State, held first sample and inter-sample timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      buf_a <= '0;
      timer <= '0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      state <= state_nxt;
      if (take_first) begin
        buf_a <= mlt;
        timer <= '0;
      end else if (state == HAVE_A) begin
        timer <= timer + TMR_W'(1);
      end
    end
  end

  // Difference in IN_W+1 signed bits, offset added in IN_W+2 signed bits.
  logic signed [IN_W:0]  diff;
  logic signed [R_W-1:0] r_comb;
  assign diff   = $signed({1'b0, mlt}) - $signed({1'b0, buf_a});
  assign r_comb = R_W'(diff) + R_W'(OFFSET);

  logic signed [R_W-1:0] r_q;
  logic                  sat_q;
  logic                  v1_q;

  // Stage 1: full-width result and the saturation mode of this pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q      <= '0;
      sat_q    <= 1'b0;
      v1_q     <= 1'b0;
      pair_cnt <= '0;
    end else begin
      v1_q <= pair_done;
      if (pair_done) begin
        r_q      <= r_comb;
        sat_q    <= sat_en;
        pair_cnt <= pair_cnt + 16'd1;
      end
    end
  end

  logic signed [SAT_MAX_W-1:0] r_ext;
  logic signed [SAT_MAX_W-1:0] r_clamp;
  logic [OUT_W-1:0]            res_c;
  logic                        ovf_c;

  // Range check and output formatting of the stage-1 result.
  always_comb begin
    r_ext   = SAT_MAX_W'(r_q);
    r_clamp = sat_signed(r_ext, OUT_W);
    ovf_c   = (r_clamp != r_ext);
    res_c   = sat_q ? r_clamp[OUT_W-1:0] : r_q[OUT_W-1:0];
  end

  logic [OUT_W-1:0] res_q;
  logic             ovf_q;
  logic             v2_q;

  // Stage 2: formatted result; holds until the next pair arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        res_q <= res_c;
        ovf_q <= ovf_c;
      end
    end
  end

  tdc_dval_delay #(
    .DEPTH  (DVAL_DELAY),
    .DATA_W (OUT_W)
  ) u_dval_delay (
    .clk       (clk),
    .rst       (rst),
    .in_data   (res_q),
    .in_ovf    (ovf_q),
    .in_valid  (v2_q),
    .out_data  (out_data),
    .out_ovf   (o_ovf),
    .out_valid (o_dval)
  );

endmodule

// File: tb/tb_tdc_pair_diff.sv
// Directed bench for tdc_pair_diff: dut_a (TIMEOUT=8, no extra delay) covers
// arithmetic, realignment and timeout; dut_b (DVAL_DELAY=3) covers streaming
// latency and mid-stream reset.
module tb_tdc_pair_diff;

  logic        clk = 1'b0;
  logic        rst;
  logic        dval;
  logic [36:0] mlt;
  logic        sync;
  logic        sat_en;

  logic [19:0] a_out_data, b_out_data;
  logic        a_dval, a_ovf, a_to;
  logic        b_dval, b_ovf, b_to;
  logic [15:0] a_cnt, b_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic to_a, to_b;

  always #5 clk = ~clk;

  tdc_pair_diff #(.TIMEOUT(8), .DVAL_DELAY(0)) dut_a (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .sync(sync), .sat_en(sat_en),
    .out_data(a_out_data), .o_dval(a_dval), .o_ovf(a_ovf), .o_timeout(a_to),
    .pair_cnt(a_cnt)
  );

  tdc_pair_diff #(.DVAL_DELAY(3)) dut_b (
    .clk(clk), .rst(rst), .dval(dval), .mlt(mlt), .sync(sync), .sat_en(sat_en),
    .out_data(b_out_data), .o_dval(b_dval), .o_ovf(b_ovf), .o_timeout(b_to),
    .pair_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; captures the combinational
  // timeout pulse of that cycle, returns just after the closing edge.
  task automatic step(input logic dv, input logic [36:0] m, input logic sy);
    dval = dv;
    mlt  = m;
    sync = sy;
    #2;
    to_a = a_to;
    to_b = b_to;
    @(posedge clk);
    #1;
    dval = 1'b0;
    sync = 1'b0;
  endtask

  // Called right after the step carrying the second sample (cycle t+1).
  task automatic finish_pair(input string tag, input logic [19:0] exp_d, input logic exp_o);
    exp_cnt++;
    check({tag, " dval@t+1"}, a_dval, 1'b0);
    check({tag, " cnt@t+1"}, a_cnt, 16'(exp_cnt));
    step(1'b0, '0, 1'b0);
    check({tag, " dval@t+2"}, a_dval, 1'b1);
    check({tag, " data"}, a_out_data, exp_d);
    check({tag, " ovf"}, a_ovf, exp_o);
    step(1'b0, '0, 1'b0);
    check({tag, " dval@t+3"}, a_dval, 1'b0);
    check({tag, " hold"}, a_out_data, exp_d);
  endtask

  task automatic run_pair(input string tag, input logic [36:0] a, input logic [36:0] b,
                          input logic se, input logic sy_a,
                          input logic [19:0] exp_d, input logic exp_o);
    sat_en = se;
    step(1'b1, a, sy_a);
    check({tag, " no_to_a"}, to_a, 1'b0);
    step(1'b1, b, 1'b0);
    check({tag, " no_to_b"}, to_a, 1'b0);
    finish_pair(tag, exp_d, exp_o);
  endtask

  initial begin
    int n_res;
    rst = 1'b0; dval = 1'b0; mlt = '0; sync = 1'b0; sat_en = 1'b1;
    #1;
    check("rst out_data", a_out_data, 20'h0);
    check("rst o_dval", a_dval, 1'b0);
    check("rst o_ovf", a_ovf, 1'b0);
    check("rst o_timeout", a_to, 1'b0);
    check("rst pair_cnt", a_cnt, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b0, '0, 1'b0);

    // Arithmetic and formatting.
    run_pair("pos", 37'd1000, 37'd1500, 1'b1, 1'b0, 20'd523, 1'b0);
    run_pair("zero", 37'd0, 37'd0, 1'b1, 1'b0, 20'd23, 1'b0);
    check("cnt after two", a_cnt, 16'd2);
    run_pair("neg", 37'd1500, 37'd1000, 1'b1, 1'b0, 20'hFFE23, 1'b0);
    run_pair("sat hi", 37'd0, 37'h100000, 1'b1, 1'b0, 20'h7FFFF, 1'b1);
    run_pair("trunc hi", 37'd0, 37'h100000, 1'b0, 1'b0, 20'h00017, 1'b1);
    run_pair("sat lo", 37'h100000, 37'd0, 1'b1, 1'b0, 20'h80000, 1'b1);
    run_pair("edge max", 37'd0, 37'd524264, 1'b1, 1'b0, 20'h7FFFF, 1'b0);

    // Realignment by a lone sync pulse.
    step(1'b1, 37'd100, 1'b0);
    step(1'b0, '0, 1'b1);
    check("realign sync no_to", to_a, 1'b0);
    check("realign no result", a_dval, 1'b0);
    run_pair("realign", 37'd200, 37'd260, 1'b1, 1'b0, 20'd83, 1'b0);

    // Realignment by sync together with dval.
    step(1'b1, 37'd100, 1'b0);
    run_pair("sync+dval", 37'd200, 37'd260, 1'b1, 1'b1, 20'd83, 1'b0);

    // Timeout: first sample at cycle 0, drop pulse in cycle 8 only.
    step(1'b1, 37'd5, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, '0, 1'b0);
      if (k == 7) check("to cycle7", to_a, 1'b0);
      if (k == 8) check("to cycle8", to_a, 1'b1);
    end
    step(1'b0, '0, 1'b0);
    check("to cycle9", to_a, 1'b0);
    check("to cnt unchanged", a_cnt, 16'(exp_cnt));
    run_pair("after to", 37'd10, 37'd20, 1'b1, 1'b0, 20'd33, 1'b0);

    // Second sample exactly in the expiry cycle wins.
    step(1'b1, 37'd5, 1'b0);
    for (int k = 1; k <= 7; k++) step(1'b0, '0, 1'b0);
    step(1'b1, 37'd50, 1'b0);
    check("expiry dval no_to", to_a, 1'b0);
    finish_pair("expiry dval", 20'd68, 1'b0);

    // Streaming with DVAL_DELAY=3: 20 back-to-back pairs, result p+23.
    rst = 1'b0;
    #1;
    check("b rst o_dval", b_dval, 1'b0);
    check("b rst cnt", b_cnt, 16'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    sat_en = 1'b1;
    n_res = 0;
    for (int k = 0; k < 50; k++) begin
      int obs;
      int p;
      bit exp_v;
      p = k / 2;
      if (k < 40) step(1'b1, (k % 2 == 0) ? 37'(p * 10) : 37'(p * 11), 1'b0);
      else        step(1'b0, '0, 1'b0);
      obs   = k + 1;
      exp_v = (obs >= 6) && (obs <= 44) && ((obs - 6) % 2 == 0);
      check($sformatf("stream dval c%0d", obs), b_dval, exp_v);
      check($sformatf("stream ovf c%0d", obs), b_ovf, 1'b0);
      if (exp_v) begin
        n_res++;
        check($sformatf("stream data c%0d", obs), b_out_data, 20'((obs - 6) / 2 + 23));
      end
    end
    check("stream results", 64'(n_res), 64'd20);
    check("stream cnt", b_cnt, 16'd20);

    // Reset mid-stream with results still in the delay line.
    for (int k = 0; k < 10; k++) step(1'b1, 37'(k * 3), 1'b0);
    rst = 1'b0;
    #1;
    check("midrst b dval", b_dval, 1'b0);
    check("midrst b data", b_out_data, 20'h0);
    check("midrst b cnt", b_cnt, 16'h0);
    check("midrst a data", a_out_data, 20'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, '0, 1'b0);
      check($sformatf("post rst quiet %0d", k), b_dval, 1'b0);
    end
    step(1'b1, 37'd7, 1'b0);
    step(1'b1, 37'd9, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step(1'b0, '0, 1'b0);
      check($sformatf("recover dval t+%0d", k), b_dval, 1'b0);
    end
    step(1'b0, '0, 1'b0);
    check("recover dval t+5", b_dval, 1'b1);
    check("recover data", b_out_data, 20'd25);
    check("recover cnt", b_cnt, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
